regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameters: XLEN, 32, data width; NREG, 32, register count (power of 2, >=2); NRP, 2, read ports; NWP, 2, write ports; BYPASS, 1, write-to-read forwarding enable; AW, $clog2(NREG), address width (derived).
REQ-002 SHALL have port: clk_i  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_ni_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: rs_addr_i  in  NRP*AW  read addresses, port p at [p*AW +: AW].
REQ-005 SHALL have port: rs_data_o  out  NRP*XLEN  read data per port.
REQ-006 SHALL have port: rs_busy_o  out  NRP  scoreboard busy flag per read port.
REQ-007 SHALL have port: wr_en_i  in  NWP  write enable per write port.
REQ-008 SHALL have port: wr_addr_i  in  NWP*AW  write addresses.
REQ-009 SHALL have port: wr_data_i  in  NWP*XLEN  write data.
REQ-010 SHALL have port: wr_clr_i  in  NWP  write also clears busy of wr_addr.
REQ-011 SHALL have port: iss_valid_i  in  1  issue strobe, marks iss_rd_i busy.
REQ-012 SHALL have port: iss_rd_i  in  AW  destination being issued.
REQ-013 SHALL have port: busy_cnt_o  out  AW+1  number of busy registers.

Function
REQ-014 SHALL read combinationally: rs_data_o[p] = reg[rs_addr_i[p]], zero-latency.
REQ-015 SHALL return 0 for address 0 on every read port regardless of writes or bypass.
REQ-016 SHALL write wr_data_i[w] into reg[wr_addr_i[w]] on rising edge when wr_en_i[w]=1 and wr_addr_i[w]!=0.
REQ-017 SHALL resolve same-cycle writes to one address: highest-index write port wins; others discarded.
REQ-018 SHALL, when BYPASS=1, drive rs_data_o[p] from the winning same-cycle write (REQ-017) whose address matches rs_addr_i[p] (nonzero); BYPASS=0 returns pre-edge contents.
REQ-019 SHALL keep busy[NREG-1:1]; busy[0] constant 0.
REQ-020 SHALL set busy[iss_rd_i] on edge when iss_valid_i=1 and iss_rd_i!=0.
REQ-021 SHALL clear busy[wr_addr_i[w]] on edge when wr_en_i[w]=1, wr_clr_i[w]=1, address nonzero.
REQ-022 SHALL give issue-set priority over clear when same register set and cleared in one cycle (new producer wins; register stays busy, data still written).
REQ-023 SHALL drive rs_busy_o[p] = busy[rs_addr_i[p]], except when BYPASS=1 and a clearing write to that address occurs this cycle, then 0.
REQ-024 SHALL drive busy_cnt_o registered: equal to popcount of busy after each edge; max NREG-1, no wrap.
REQ-025 SHALL treat wr_en_i=0 with wr_clr_i=1 as no-op.
REQ-026 SHALL set busy on re-issue of already-busy register without changing busy_cnt_o.

Reset
REQ-027 SHALL, on rst_ni_i=0, asynchronously clear all registers, all busy bits and busy_cnt_o to 0, independent of clk_i.
REQ-028 SHALL ignore writes/issues while rst_ni_i=0; first effective update on first rising edge after deassertion.
REQ-029 SHALL return 0 on all rs_data_o and rs_busy_o during reset (all state zero).

Structure
REQ-030 SHALL place default XLEN/NREG constants and the AW derivation helper in shared package rv_pkg.
REQ-031 SHALL implement scoreboard (busy bits, counter) as sub-module regfile_sb; data array and bypass mux in regfile_mp.
REQ-032 SHALL be synthesizable for any legal parameter set without code edits.

Verification
REQ-033 SHALL cover: reset, write x5=0xDEADBEEF port0, read x5 next cycle -> 0xDEADBEEF; assert rst_ni_i mid-cycle -> x5 reads 0 immediately.
REQ-034 SHALL cover: write x0=0xFFFFFFFF both ports -> x0 reads 0, busy_cnt_o=0.
REQ-035 SHALL cover: port0 writes x7=0x11, port1 writes x7=0x22 same cycle -> bypass read 0x22, next cycle read 0x22.
REQ-036 SHALL cover: BYPASS=1, write x3=0xA5A5 while rs_addr=3 -> rs_data_o=0xA5A5 same cycle; BYPASS=0 -> old value 0.
REQ-037 SHALL cover: issue x9, next cycle rs_busy_o=1, busy_cnt_o=1; clearing write x9 same cycle as issue x9 -> stays busy, count 1; lone clear -> count 0.
REQ-038 SHALL cover: issue all x1..x31 -> busy_cnt_o=31, re-issue x1 -> 31, no wrap.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file defaults and address-width helper
//   XLEN_D / NREG_D : default data width and register count
//   aw_of(n)        : address bits needed to index n registers (min 1)
package rv_pkg;
  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;
  function automatic int aw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_sb.sv
// regfile_sb: busy scoreboard with registered population count
//   clk_i, rst_ni_i              : clock, async active-low reset
//   wr_en_i/wr_addr_i/wr_clr_i   : per write port, a clearing write drops busy
//   iss_valid_i/iss_rd_i         : issue strobe marking a destination busy
//   busy_o                       : busy vector (bit 0 always 0)
//   busy_cnt_o                   : number of busy registers, registered
module regfile_sb
  import rv_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int NWP  = 2,
  parameter int AW   = aw_of(NREG)
) (
  input  logic              clk_i,
  input  logic              rst_ni_i,
  input  logic [NWP-1:0]    wr_en_i,
  input  logic [NWP*AW-1:0] wr_addr_i,
  input  logic [NWP-1:0]    wr_clr_i,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_rd_i,
  output logic [NREG-1:0]   busy_o,
  output logic [AW:0]       busy_cnt_o
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nx;
  logic [AW:0]     r_cnt;
  logic [AW:0]     w_cnt_nx;
  // clears first, then the issue set, so a new producer outranks a retiring one
  always_comb begin
    w_busy_nx = r_busy;
    for (int w = 0; w < NWP; w++)
      if (wr_en_i[w] && wr_clr_i[w] && wr_addr_i[w*AW +: AW] != '0)
        w_busy_nx[wr_addr_i[w*AW +: AW]] = 1'b0;
    if (iss_valid_i && iss_rd_i != '0)
      w_busy_nx[iss_rd_i] = 1'b1;
    w_busy_nx[0] = 1'b0;
    w_cnt_nx = '0;
    for (int i = 0; i < NREG; i++)
      w_cnt_nx = w_cnt_nx + (AW+1)'(w_busy_nx[i]);
  end
  always_ff @(posedge clk_i or negedge rst_ni_i)
    if (!rst_ni_i) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nx;
      r_cnt  <= w_cnt_nx;
    end
  assign busy_o     = r_busy;
  assign busy_cnt_o = r_cnt;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hardwired to zero, optional
// write-to-read bypass and a busy scoreboard
//   clk_i, rst_ni_i                   : clock, async active-low reset
//   rs_addr_i/rs_data_o/rs_busy_o     : NRP combinational read ports
//   wr_en_i/wr_addr_i/wr_data_i/wr_clr_i : NWP write ports, highest index wins
//   iss_valid_i/iss_rd_i              : issue strobe marking a destination busy
//   busy_cnt_o                        : number of busy registers
module regfile_mp
  import rv_pkg::*;
#(
  parameter int XLEN   = XLEN_D,
  parameter int NREG   = NREG_D,
  parameter int NRP    = 2,
  parameter int NWP    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = aw_of(NREG)
) (
  input  logic                clk_i,
  input  logic                rst_ni_i,
  input  logic [NRP*AW-1:0]   rs_addr_i,
  output logic [NRP*XLEN-1:0] rs_data_o,
  output logic [NRP-1:0]      rs_busy_o,
  input  logic [NWP-1:0]      wr_en_i,
  input  logic [NWP*AW-1:0]   wr_addr_i,
  input  logic [NWP*XLEN-1:0] wr_data_i,
  input  logic [NWP-1:0]      wr_clr_i,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  output logic [AW:0]         busy_cnt_o
);
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] w_busy;
  regfile_sb #(.NREG(NREG), .NWP(NWP), .AW(AW)) u_sb (
    .clk_i      (clk_i),
    .rst_ni_i   (rst_ni_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_clr_i   (wr_clr_i),
    .iss_valid_i(iss_valid_i),
    .iss_rd_i   (iss_rd_i),
    .busy_o     (w_busy),
    .busy_cnt_o (busy_cnt_o)
  );
  // ascending port order: the last nonblocking write, the highest port, wins
  always_ff @(posedge clk_i or negedge rst_ni_i)
    if (!rst_ni_i) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int w = 0; w < NWP; w++)
        if (wr_en_i[w] && wr_addr_i[w*AW +: AW] != '0)
          r_regs[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
    end
  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0]   w_a;
    logic [XLEN-1:0] w_d;
    logic            w_b;
    assign w_a = rs_addr_i[p*AW +: AW];
    // forwarding is suppressed in reset so the outputs reflect the cleared state
    always_comb begin
      w_d = r_regs[w_a];
      w_b = w_busy[w_a];
      for (int w = 0; w < NWP; w++)
        if (BYPASS != 0 && rst_ni_i && wr_en_i[w] && wr_addr_i[w*AW +: AW] == w_a) begin
          w_d = wr_data_i[w*XLEN +: XLEN];
          if (wr_clr_i[w]) w_b = 1'b0;
        end
    end
    assign rs_data_o[p*XLEN +: XLEN] = (w_a == '0) ? '0 : w_d;
    assign rs_busy_o[p]              = (w_a == '0) ? 1'b0 : w_b;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp against a behavioural model
module tb_regfile_mp;
  localparam int XLEN = 32, NREG = 32, NRP = 2, NWP = 2, AW = 5;
  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRP*AW-1:0]   rs_addr;
  logic [NWP-1:0]      wr_en, wr_clr;
  logic [NWP*AW-1:0]   wr_addr;
  logic [NWP*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic [NRP*XLEN-1:0] data_b, data_n;
  logic [NRP-1:0]      busy_b, busy_n;
  logic [AW:0]         cnt_b, cnt_n;
  logic [XLEN-1:0]     m_reg [NREG];
  logic                m_busy [NREG];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .BYPASS(1)) u_byp (
    .clk_i(clk), .rst_ni_i(rst_n), .rs_addr_i(rs_addr), .rs_data_o(data_b), .rs_busy_o(busy_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_clr_i(wr_clr),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .busy_cnt_o(cnt_b));
  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .BYPASS(0)) u_nob (
    .clk_i(clk), .rst_ni_i(rst_n), .rs_addr_i(rs_addr), .rs_data_o(data_n), .rs_busy_o(busy_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_clr_i(wr_clr),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .busy_cnt_o(cnt_n));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic void clr_model();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endfunction
  function automatic int pop();
    int n = 0;
    for (int r = 0; r < NREG; r++) n += int'(m_busy[r]);
    return n;
  endfunction
  function automatic logic [XLEN-1:0] exp_data(input int p, input bit byp);
    logic [AW-1:0] a = rs_addr[p*AW +: AW];
    if (a == 0) return '0;
    if (byp && rst_n)
      for (int w = NWP - 1; w >= 0; w--)
        if (wr_en[w] && wr_addr[w*AW +: AW] == a) return wr_data[w*XLEN +: XLEN];
    return m_reg[a];
  endfunction
  function automatic logic exp_busy(input int p, input bit byp);
    logic [AW-1:0] a = rs_addr[p*AW +: AW];
    if (a == 0) return 1'b0;
    if (byp && rst_n)
      for (int w = 0; w < NWP; w++)
        if (wr_en[w] && wr_clr[w] && wr_addr[w*AW +: AW] == a) return 1'b0;
    return m_busy[a];
  endfunction
  task automatic drive(input logic [1:0] en, input logic [1:0] clr,
                       input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                       input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                       input logic iv, input logic [AW-1:0] rd,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    wr_en = en; wr_clr = clr; wr_addr = {a1, a0}; wr_data = {d1, d0};
    iss_valid = iv; iss_rd = rd; rs_addr = {r1, r0};
  endtask
  task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 0, r0, r1);
  endtask
  // called just after a negedge with inputs set: checks combinational outputs,
  // advances the model across the rising edge, then checks the counter
  task automatic cyc();
    logic [XLEN-1:0] nr [NREG];
    logic            nb [NREG];
    #1;
    if (!rst_n) clr_model();
    for (int p = 0; p < NRP; p++) begin
      check($sformatf("data_byp%0d", p), 64'(data_b[p*XLEN +: XLEN]), 64'(exp_data(p, 1'b1)));
      check($sformatf("data_nob%0d", p), 64'(data_n[p*XLEN +: XLEN]), 64'(exp_data(p, 1'b0)));
      check($sformatf("busy_byp%0d", p), 64'(busy_b[p]), 64'(exp_busy(p, 1'b1)));
      check($sformatf("busy_nob%0d", p), 64'(busy_n[p]), 64'(exp_busy(p, 1'b0)));
    end
    if (rst_n) begin
      for (int r = 1; r < NREG; r++) begin
        nr[r] = m_reg[r];
        nb[r] = m_busy[r];
        for (int w = 0; w < NWP; w++)
          if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == r) begin
            nr[r] = wr_data[w*XLEN +: XLEN];
            if (wr_clr[w]) nb[r] = 1'b0;
          end
        if (iss_valid && int'(iss_rd) == r) nb[r] = 1'b1;
      end
      for (int r = 1; r < NREG; r++) begin
        m_reg[r]  = nr[r];
        m_busy[r] = nb[r];
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) clr_model();
    check("cnt_byp", 64'(cnt_b), 64'(pop()));
    check("cnt_nob", 64'(cnt_n), 64'(pop()));
    @(negedge clk);
  endtask
  initial begin
    clr_model();
    rst_n = 1'b0;
    drive(2'b11, 2'b11, 5, 32'h1234, 6, 32'h5678, 1'b1, 5, 5, 6);
    @(negedge clk);
    cyc();
    cyc();
    rst_n = 1'b1;
    drive(2'b01, 2'b00, 5, 32'hDEADBEEF, 0, 0, 1'b0, 0, 0, 0);
    cyc();
    idle(5, 0);
    #1;
    check("x5_read", 64'(data_b[XLEN-1:0]), 64'h0000_0000_DEAD_BEEF);
    #2;
    rst_n = 1'b0;
    #1;
    check("x5_async_rst", 64'(data_b[XLEN-1:0]), 64'h0);
    check("x5_async_rst_nob", 64'(data_n[XLEN-1:0]), 64'h0);
    clr_model();
    @(negedge clk);
    rst_n = 1'b1;
    idle(5, 0);
    cyc();
    drive(2'b11, 2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1'b0, 0, 0, 0);
    cyc();
    check("x0_cnt", 64'(cnt_b), 64'h0);
    drive(2'b11, 2'b00, 7, 32'h11, 7, 32'h22, 1'b0, 0, 7, 0);
    #1;
    check("x7_bypass", 64'(data_b[XLEN-1:0]), 64'h22);
    cyc();
    idle(7, 7);
    cyc();
    check("x7_next", 64'(data_n[XLEN +: XLEN]), 64'h22);
    drive(2'b01, 2'b00, 3, 32'hA5A5, 0, 0, 1'b0, 0, 3, 0);
    #1;
    check("x3_byp", 64'(data_b[XLEN-1:0]), 64'hA5A5);
    check("x3_nobyp", 64'(data_n[XLEN-1:0]), 64'h0);
    cyc();
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b1, 9, 9, 0);
    cyc();
    check("x9_busy", 64'(busy_b[0]), 64'h1);
    check("x9_cnt", 64'(cnt_b), 64'h1);
    drive(2'b01, 2'b01, 9, 32'h99, 0, 0, 1'b1, 9, 9, 0);
    cyc();
    check("x9_reissue_cnt", 64'(cnt_b), 64'h1);
    drive(2'b10, 2'b10, 0, 0, 9, 32'h9A, 1'b0, 0, 9, 0);
    cyc();
    check("x9_clear_cnt", 64'(cnt_b), 64'h0);
    drive(2'b00, 2'b11, 0, 0, 9, 0, 1'b1, 9, 9, 9);
    cyc();
    drive(2'b00, 2'b11, 9, 0, 9, 0, 1'b0, 0, 9, 1);
    cyc();
    check("clr_noen_cnt", 64'(cnt_b), 64'h1);
    for (int r = 1; r < NREG; r++) begin
      drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b1, AW'(r), AW'(r), 1);
      cyc();
    end
    check("all_busy_cnt", 64'(cnt_b), 64'd31);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b1, 1, 1, 31);
    cyc();
    check("all_busy_reissue", 64'(cnt_b), 64'd31);
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive(2'($urandom), 2'($urandom),
            AW'($urandom_range(0, 7)), $urandom, AW'($urandom_range(0, 7)), $urandom,
            1'($urandom), AW'($urandom_range(0, 9)),
            AW'($urandom_range(0, 9)), AW'($urandom));
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
